// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU with a single tagged response port.
// Build option: define ALU_ARB_FIXED_PRI_EN for fixed priority (r0 wins ties); default is round-robin.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned FSEC_W  = 5,
  parameter int unsigned ALU_LAT = 1   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [WIDTH-1:0]  r0_a,
  input  logic [WIDTH-1:0]  r0_b,
  input  logic [FSEC_W-1:0] r0_fsec,
  input  logic              r0_carry,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [WIDTH-1:0]  r1_a,
  input  logic [WIDTH-1:0]  r1_b,
  input  logic [FSEC_W-1:0] r1_fsec,
  input  logic              r1_carry,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [FSEC_W-1:0] alu_fsec,
  output logic              alu_carry,
  input  logic [WIDTH-1:0]  alu_fout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             grant;

  // Winner among the valid requesters; a tie goes to whoever did not win last.
  always_comb begin
    grant = 1'b0;
    if (r0_valid && r1_valid) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (r1_valid) begin
      grant = 1'b1;
    end
  end

  assign r0_ready = (state == IDLE) && r0_valid && !grant;
  assign r1_ready = (state == IDLE) && r1_valid &&  grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fsec   <= '0;
      alu_carry  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_ready || r1_ready) begin
            alu_a      <= grant ? r1_a     : r0_a;
            alu_b      <= grant ? r1_b     : r0_b;
            alu_fsec   <= grant ? r1_fsec  : r0_fsec;
            alu_carry  <= grant ? r1_carry : r0_carry;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= CNT_W'(ALU_LAT - 1);
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // alu_* stay driven while the ALU result settles for ALU_LAT cycles.
          if (cnt == '0) begin
            rsp_data  <= alu_fout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed corner sequences and a randomized
// run against a transaction-timeline reference model (ALU_LAT=1 and ALU_LAT=3 instances).
module tb_alu_arbiter;

  localparam int unsigned W  = 64;
  localparam int unsigned FW = 5;
`ifdef ALU_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          r0_valid, r0_carry, r1_valid, r1_carry, rsp_ready;
  logic [W-1:0]  r0_a, r0_b, r1_a, r1_b;
  logic [FW-1:0] r0_fsec, r1_fsec;

  logic          d1_r0_ready, d1_r1_ready, d1_alu_carry, d1_rsp_valid, d1_rsp_id, d1_busy;
  logic [W-1:0]  d1_alu_a, d1_alu_b, d1_fout, d1_rsp_data;
  logic [FW-1:0] d1_alu_fsec;
  logic          d3_r0_ready, d3_r1_ready, d3_alu_carry, d3_rsp_valid, d3_rsp_id, d3_busy;
  logic [W-1:0]  d3_alu_a, d3_alu_b, d3_fout, d3_rsp_data;
  logic [FW-1:0] d3_alu_fsec;

  int checks = 0;
  int errors = 0;

  // Stub ALU: 0 add, 1 add-with-carry, 2 sub, 3 xor, others and.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [FW-1:0] f, input logic c);
    case (f)
      5'd0:    return a + b;
      5'd1:    return a + b + W'(c);
      5'd2:    return a - b;
      5'd3:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign d1_fout = ref_alu(d1_alu_a, d1_alu_b, d1_alu_fsec, d1_alu_carry);
  assign d3_fout = ref_alu(d3_alu_a, d3_alu_b, d3_alu_fsec, d3_alu_carry);

  alu_arbiter #(.WIDTH(W), .FSEC_W(FW), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(d1_r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_fsec(r0_fsec), .r0_carry(r0_carry),
    .r1_valid(r1_valid), .r1_ready(d1_r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_fsec(r1_fsec), .r1_carry(r1_carry),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_fsec(d1_alu_fsec), .alu_carry(d1_alu_carry),
    .alu_fout(d1_fout),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d1_rsp_id),
    .rsp_data(d1_rsp_data), .busy(d1_busy)
  );

  alu_arbiter #(.WIDTH(W), .FSEC_W(FW), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(d3_r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_fsec(r0_fsec), .r0_carry(r0_carry),
    .r1_valid(r1_valid), .r1_ready(d3_r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_fsec(r1_fsec), .r1_carry(r1_carry),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_fsec(d3_alu_fsec), .alu_carry(d3_alu_carry),
    .alu_fout(d3_fout),
    .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d3_rsp_id),
    .rsp_data(d3_rsp_data), .busy(d3_busy)
  );

  // View of whichever instance the current test targets.
  logic         sel3 = 1'b0;
  logic         s_r0_ready, s_r1_ready, s_rsp_valid, s_rsp_id, s_busy;
  logic [W-1:0] s_rsp_data;
  assign s_r0_ready  = sel3 ? d3_r0_ready  : d1_r0_ready;
  assign s_r1_ready  = sel3 ? d3_r1_ready  : d1_r1_ready;
  assign s_rsp_valid = sel3 ? d3_rsp_valid : d1_rsp_valid;
  assign s_rsp_id    = sel3 ? d3_rsp_id    : d1_rsp_id;
  assign s_busy      = sel3 ? d3_busy      : d1_busy;
  assign s_rsp_data  = sel3 ? d3_rsp_data  : d1_rsp_data;

  typedef struct {
    logic          id;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [FW-1:0] fsec;
    logic          carry;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [FW-1:0] f, input logic c);
    if (id) begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_fsec = f; r1_carry = c;
    end else begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_fsec = f; r0_carry = c;
    end
  endtask

  task automatic clr_req();
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after accept) at which rsp_valid is seen; 0 on timeout.
  task automatic wait_rsp(output int k);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (s_rsp_valid) begin
        k = i;
        break;
      end
      tick();
    end
  endtask

  task automatic run_random(input logic use3, input int lat, input int ncyc);
    logic m_busy, m_id, m_last, acc0, acc1, g, e0, e1, erv;
    int m_cyc;
    logic [W-1:0] m_data;
    sel3 = use3;
    do_reset();
    m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    m_cyc = 0; m_data = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (!r0_valid || acc0) begin
        r0_valid = ($urandom % 2) == 1;
        r0_a = {$urandom, $urandom}; r0_b = {$urandom, $urandom};
        r0_fsec = FW'($urandom % 6); r0_carry = 1'($urandom);
      end else if ($urandom % 8 == 0) begin
        r0_valid = 1'b0;
      end
      if (!r1_valid || acc1) begin
        r1_valid = ($urandom % 2) == 1;
        r1_a = {$urandom, $urandom}; r1_b = {$urandom, $urandom};
        r1_fsec = FW'($urandom % 6); r1_carry = 1'($urandom);
      end else if ($urandom % 8 == 0) begin
        r1_valid = 1'b0;
      end
      rsp_ready = ($urandom % 4) != 0;
      @(negedge clk);
      // Tie: fixed priority favours r0, round-robin favours the one that did not win last.
      if (r0_valid && r1_valid) g = FIXED ? 1'b0 : !m_last;
      else                      g = r1_valid;
      e0  = !m_busy && r0_valid && !g;
      e1  = !m_busy && r1_valid && g;
      erv = m_busy && (c >= m_cyc);
      chk("rnd_r0_ready", s_r0_ready, e0);
      chk("rnd_r1_ready", s_r1_ready, e1);
      chk("rnd_rsp_valid", s_rsp_valid, erv);
      chk("rnd_busy", s_busy, m_busy);
      if (erv) begin
        chk("rnd_rsp_id", s_rsp_id, m_id);
        chk("rnd_rsp_data", s_rsp_data, m_data);
      end
      acc0 = e0; acc1 = e1;
      if (e0 || e1) begin
        m_busy = 1'b1; m_cyc = c + 1 + lat; m_id = e1; m_last = e1;
        m_data = e1 ? ref_alu(r1_a, r1_b, r1_fsec, r1_carry)
                    : ref_alu(r0_a, r0_b, r0_fsec, r0_carry);
      end else if (erv && rsp_ready) begin
        m_busy = 1'b0;
      end
      tick();
    end
    clr_req();
    rsp_ready = 1'b1;
    repeat (lat + 4) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, gcnt, last_c;
    logic [W-1:0] hold_data;

    vecs[0] = '{1'b0, 64'd5, 64'd3, 5'd0, 1'b0, 64'd8};
    vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 1'b0, 64'd0};
    vecs[2] = '{1'b0, 64'd10, 64'd20, 5'd1, 1'b1, 64'd31};
    vecs[3] = '{1'b1, 64'd3, 64'd5, 5'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[4] = '{1'b0, 64'hF0F0, 64'h0FF0, 5'd3, 1'b0, 64'hFF00};
    vecs[5] = '{1'b1, 64'hFF, 64'h0F, 5'd7, 1'b1, 64'h0F};

    rst = 1'b1; rsp_ready = 1'b0;
    r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_fsec = '0; r0_carry = 1'b0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_fsec = '0; r1_carry = 1'b0;
    @(posedge clk);
    tick();
    rst = 1'b0;

    // Reset state of both instances
    @(negedge clk);
    chk("rst_rsp_valid", {d1_rsp_valid, d3_rsp_valid}, 0);
    chk("rst_busy", {d1_busy, d3_busy}, 0);
    chk("rst_rsp_id", {d1_rsp_id, d3_rsp_id}, 0);
    chk("rst_rsp_data", d1_rsp_data | d3_rsp_data, 0);
    chk("rst_alu_a", d1_alu_a | d3_alu_a, 0);
    chk("rst_alu_b", d1_alu_b | d3_alu_b, 0);
    chk("rst_alu_fsec", {d1_alu_fsec, d3_alu_fsec}, 0);
    chk("rst_alu_carry", {d1_alu_carry, d3_alu_carry}, 0);
    chk("rst_ready", {d1_r0_ready, d1_r1_ready, d3_r0_ready, d3_r1_ready}, 0);
    tick();

    // Vector table, single requester each, ALU_LAT=1
    sel3 = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].fsec, vecs[i].carry);
      @(negedge clk);
      chk("tbl_ready", vecs[i].id ? s_r1_ready : s_r0_ready, 1);
      tick();
      clr_req();
      wait_rsp(k);
      chk("tbl_latency", 64'(k), 2);
      chk("tbl_rsp_id", s_rsp_id, vecs[i].id);
      chk("tbl_rsp_data", s_rsp_data, vecs[i].exp);
      chk("tbl_busy_resp", s_busy, 1);
      tick();
      @(negedge clk);
      chk("tbl_busy_idle", s_busy, 0);
      chk("tbl_rsp_cleared", s_rsp_valid, 0);
      tick();
    end

    // Both requesters valid continuously: alternating grants (r0 only when fixed)
    do_reset();
    rsp_ready = 1'b1;
    set_req(1'b0, 64'd1, 64'd1, 5'd0, 1'b0);
    set_req(1'b1, 64'd2, 64'd2, 5'd0, 1'b0);
    gcnt = 0; last_c = 0;
    for (int c = 0; c < 40 && gcnt < 6; c++) begin
      @(negedge clk);
      chk("rr_exclusive", s_r0_ready & s_r1_ready, 0);
      if (s_r0_ready || s_r1_ready) begin
        chk("rr_grant", s_r1_ready, FIXED ? 0 : 64'(gcnt % 2));
        if (gcnt > 0) chk("rr_gap", 64'(c - last_c), 3);
        last_c = c;
        gcnt++;
      end
      tick();
    end
    chk("rr_count", 64'(gcnt), 6);
    clr_req();

    // Response back-pressure for 5 cycles
    do_reset();
    set_req(1'b0, 64'd7, 64'd9, 5'd0, 1'b0);
    @(negedge clk);
    chk("bp_accept", s_r0_ready, 1);
    tick();
    set_req(1'b0, 64'd1, 64'd2, 5'd0, 1'b0);
    set_req(1'b1, 64'd4, 64'd4, 5'd0, 1'b0);
    wait_rsp(k);
    chk("bp_latency", 64'(k), 2);
    hold_data = 64'd16;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", s_rsp_valid, 1);
      chk("bp_rsp_data", s_rsp_data, hold_data);
      chk("bp_rsp_id", s_rsp_id, 0);
      chk("bp_no_ready", {s_r0_ready, s_r1_ready}, 0);
      chk("bp_busy", s_busy, 1);
      tick();
      if (i == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    tick();
    @(negedge clk);
    chk("bp_idle_busy", s_busy, 0);
    chk("bp_idle_rsp", s_rsp_valid, 0);
    chk("bp_next_r1", s_r1_ready, FIXED ? 0 : 1);
    chk("bp_next_r0", s_r0_ready, FIXED ? 1 : 0);
    tick();
    clr_req();
    repeat (4) tick();

    // ALU_LAT=3 with wrap-around add
    sel3 = 1'b1;
    do_reset();
    rsp_ready = 1'b1;
    set_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 1'b0);
    @(negedge clk);
    chk("lat3_accept", s_r0_ready, 1);
    tick();
    clr_req();
    wait_rsp(k);
    chk("lat3_latency", 64'(k), 4);
    chk("lat3_rsp_data", s_rsp_data, 0);
    chk("lat3_rsp_id", s_rsp_id, 0);
    tick();
    sel3 = 1'b0;

    // Reset pulsed during EXEC discards the op
    do_reset();
    rsp_ready = 1'b1;
    set_req(1'b1, 64'd5, 64'd3, 5'd0, 1'b0);
    @(negedge clk);
    chk("rstx_accept", s_r1_ready, 1);
    tick();
    clr_req();
    @(negedge clk);
    chk("rstx_busy", s_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstx_alu_a", d1_alu_a, 0);
    chk("rstx_alu_b", d1_alu_b, 0);
    chk("rstx_alu_fsec_carry", {d1_alu_fsec, d1_alu_carry}, 0);
    chk("rstx_rsp", {s_rsp_id, s_busy}, 0);
    chk("rstx_rsp_data", s_rsp_data, 0);
    for (int i = 0; i < 6; i++) begin
      chk("rstx_no_rsp", s_rsp_valid, 0);
      tick();
      @(negedge clk);
    end
    tick();
    set_req(1'b0, 64'd2, 64'd2, 5'd0, 1'b0);
    set_req(1'b1, 64'd9, 64'd9, 5'd0, 1'b0);
    @(negedge clk);
    chk("rstx_tie_r0", s_r0_ready, 1);
    chk("rstx_tie_r1", s_r1_ready, 0);
    tick();
    clr_req();
    wait_rsp(k);
    chk("rstx_after_data", s_rsp_data, 64'd4);
    tick();

    // r1 alone after an r1 grant is granted again
    do_reset();
    rsp_ready = 1'b1;
    set_req(1'b1, 64'd6, 64'd7, 5'd0, 1'b0);
    @(negedge clk);
    chk("r1again_first", s_r1_ready, 1);
    tick();
    clr_req();
    wait_rsp(k);
    chk("r1again_data1", s_rsp_data, 64'd13);
    tick();
    set_req(1'b1, 64'd1, 64'd1, 5'd0, 1'b0);
    @(negedge clk);
    chk("r1again_second", s_r1_ready, 1);
    chk("r1again_r0", s_r0_ready, 0);
    tick();
    clr_req();
    wait_rsp(k);
    chk("r1again_data2", s_rsp_data, 64'd2);
    chk("r1again_id", s_rsp_id, 1);
    tick();

    // Randomized traffic against the timeline model
    run_random(1'b0, 1, 400);
    run_random(1'b1, 3, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
